// File: rtl/uart_pkg.sv
// Shared receiver types and constants: FSM states, oversample tick positions,
// and small bit-level helpers used by the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int         OVERSAMPLE   = 16;
  localparam logic [3:0] SAMPLE_MID_A = 4'd7;
  localparam logic [3:0] SAMPLE_MID_B = 4'd8;
  localparam logic [3:0] SAMPLE_MID_C = 4'd9;
  localparam logic [3:0] TICK_LAST    = 4'(OVERSAMPLE - 1);

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every BAUD_DIV clocks, free-running,
// restarted by a synchronous clear so the first tick lands BAUD_DIV clocks later.
module uart_baud_tick #(
  parameter int BAUD_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST) && !clr;

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver; o_rxdone/o_frame_err one clock after the stop-bit mid sample.
// No backpressure: each good frame overwrites o_rxdataout. UART_PARITY_EN adds an even-parity bit.
module uart_rx_oversample #(
  parameter int BAUD_DIV  = 5,
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_rxdataout,
  output logic                 o_rxdone,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);
  import uart_pkg::*;

  localparam logic [3:0] DATA_CNT = 4'(DATA_BITS);

  logic                 rxd_m;
  logic                 rxd_s;
  rx_state_e            state_q;
  rx_state_e            state_d;
  logic                 tick;
  logic                 cnt_clr;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic                 samp_a;
  logic                 samp_b;
  logic [DATA_BITS-1:0] shift_q;
  logic                 decide;
  logic                 wrap;
  logic                 bit_val;
  logic                 shift_en;
  logic                 done_set;
  logic                 ferr_set;
`ifdef UART_PARITY_EN
  logic                 par_chk;
  logic                 perr_set;
  logic                 par_bad_q;
`endif

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk  (i_clk),
    .rst_n(i_reset),
    .clr  (cnt_clr),
    .tick (tick)
  );

  assign decide  = tick && (tick_cnt == SAMPLE_MID_C);
  assign wrap    = tick && (tick_cnt == TICK_LAST);
  assign bit_val = maj3(samp_a, samp_b, rxd_s);
  assign o_busy  = (state_q != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    done_set = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_PARITY_EN
    par_chk  = 1'b0;
    perr_set = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_d = ST_START;
          cnt_clr = 1'b1;
        end
      end
      ST_START: begin
        if (decide && bit_val) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        shift_en = decide;
        if (wrap && bit_cnt == DATA_CNT) begin
`ifdef UART_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        par_chk = decide;
        if (wrap) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leave at the mid-bit decision so a following start edge is caught.
        if (decide) begin
          if (bit_val) begin
`ifdef UART_PARITY_EN
            if (par_bad_q) begin
              perr_set = 1'b1;
            end else begin
              done_set = 1'b1;
            end
`else
            done_set = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rxd_m       <= 1'b1;
      rxd_s       <= 1'b1;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      samp_a      <= 1'b0;
      samp_b      <= 1'b0;
      shift_q     <= '0;
      o_rxdataout <= '0;
      o_rxdone    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rxd_m <= i_rxd;
      rxd_s <= rxd_m;

      if (cnt_clr) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (tick && state_q != ST_IDLE) begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        if (shift_en) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (tick && tick_cnt == SAMPLE_MID_A) begin
        samp_a <= rxd_s;
      end
      if (tick && tick_cnt == SAMPLE_MID_B) begin
        samp_b <= rxd_s;
      end

      // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
      if (shift_en) begin
        shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
      end

      o_rxdone    <= done_set;
      o_frame_err <= ferr_set;
      if (done_set) begin
        o_rxdataout <= shift_q;
      end
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      par_bad_q    <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (cnt_clr) begin
        par_bad_q <= 1'b0;
      end else if (par_chk) begin
        par_bad_q <= bit_val ^ even_parity(8'(shift_q));
      end
      o_parity_err <= perr_set;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
